// File: rtl/riscv_v_hs_stage_pkg.sv
// Shared constants for the vector handshake pipeline stage and its slots.
package riscv_v_hs_stage_pkg;

  localparam int unsigned RISCV_V_NUM_ELEMENTS_REG = 8;
  localparam int unsigned RISCV_V_HS_MAX_STAGES    = 16;

  // Width of a 0..n counter; never narrower than one bit.
  function automatic int unsigned occ_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/riscv_v_hs_slot.sv
// One elastic register slot: valid bit plus payload, advancing when downstream is ready.
module riscv_v_hs_slot
  import riscv_v_hs_stage_pkg::*;
#(
  parameter int unsigned DATA_W = RISCV_V_NUM_ELEMENTS_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              v_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic              r_out,
  output logic              v,
  output logic [DATA_W-1:0] d,
  output logic              r_in
);

  assign r_in = r_out | ~v;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (r_in) begin
      v <= v_in;
      if (v_in) d <= d_in;
    end
  end

endmodule

// File: rtl/riscv_v_hs_stage.sv
// Back-pressurable valid/ready pipeline of NUM_STAGES slots with bubble collapse.
// Optional occupancy counter port when RISCV_V_HS_STAGE_OCC_EN is defined.
module riscv_v_hs_stage
  import riscv_v_hs_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = RISCV_V_NUM_ELEMENTS_REG,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef RISCV_V_HS_STAGE_OCC_EN
  ,
  output logic [occ_w(NUM_STAGES)-1:0] occupancy
`endif
);

  localparam int unsigned OCC_W = occ_w(NUM_STAGES);

  if (NUM_STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign in_ready  = out_ready & ~flush;
    assign out_valid = in_valid & ~flush;
    assign out_data  = in_data;
`ifdef RISCV_V_HS_STAGE_OCC_EN
    assign occupancy = '0;
`endif
  end else begin : g_pipe
    logic [NUM_STAGES:0]   v;
    logic [DATA_W-1:0]     d [NUM_STAGES+1];
    logic [NUM_STAGES:1]   rdn;
    logic [NUM_STAGES:1]   r;
    logic                  unused_r;

    assign v[0]     = in_valid;
    assign d[0]     = in_data;
    assign unused_r = ^r;

    // Downstream readiness is a flat OR over the later valids rather than a
    // slot-to-slot chain; same function, but no combinational self-loop.
    always_comb begin
      rdn = '0;
      for (int unsigned i = 1; i <= NUM_STAGES; i++) begin
        rdn[i] = out_ready;
        for (int unsigned j = i + 1; j <= NUM_STAGES; j++) begin
          if (!v[j]) rdn[i] = 1'b1;
        end
      end
    end

    for (genvar i = 1; i <= NUM_STAGES; i++) begin : g_slot
      riscv_v_hs_slot #(.DATA_W(DATA_W)) u_slot (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .v_in  (v[i-1]),
        .d_in  (d[i-1]),
        .r_out (rdn[i]),
        .v     (v[i]),
        .d     (d[i]),
        .r_in  (r[i])
      );
    end

    assign in_ready  = r[1] & ~flush;
    assign out_valid = v[NUM_STAGES] & ~flush;
    assign out_data  = d[NUM_STAGES];

`ifdef RISCV_V_HS_STAGE_OCC_EN
    logic in_fire;
    logic out_fire;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        occupancy <= '0;
      end else if (in_fire && !out_fire) begin
        occupancy <= occupancy + OCC_W'(1);
      end else if (out_fire && !in_fire) begin
        occupancy <= occupancy - OCC_W'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_riscv_v_hs_stage.sv
// Self-checking bench: N=2 against a word-position queue model, N=3 collapse, N=0 pass-through.
module tb_riscv_v_hs_stage;

  localparam int N2 = 2;

  logic clk;
  logic rst;

  logic       a_flush, a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_id, a_od;
  logic       b_flush, b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_id, b_od;
  logic       c_flush, c_iv, c_ir, c_ov, c_or;
  logic [7:0] c_id, c_od;
`ifdef RISCV_V_HS_STAGE_OCC_EN
  logic [1:0] a_occ, b_occ;
  logic [0:0] c_occ;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: queue of words in flight with their stage position; mlast is the
  // payload last delivered into the final stage (what out_data shows).
  logic [7:0] md[$];
  int         mp[$];
  logic [7:0] mlast;

  riscv_v_hs_stage #(.DATA_W(8), .NUM_STAGES(2)) u_n2 (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od)
`ifdef RISCV_V_HS_STAGE_OCC_EN
    , .occupancy(a_occ)
`endif
  );

  riscv_v_hs_stage #(.DATA_W(8), .NUM_STAGES(3)) u_n3 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od)
`ifdef RISCV_V_HS_STAGE_OCC_EN
    , .occupancy(b_occ)
`endif
  );

  riscv_v_hs_stage #(.DATA_W(8), .NUM_STAGES(0)) u_n0 (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od)
`ifdef RISCV_V_HS_STAGE_OCC_EN
    , .occupancy(c_occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the N=2 instance: drive, check against model, clock, advance model.
  task automatic step2(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic fl, input logic rs);
    logic       e_ir, e_ov;
    int         lim, np;
    logic [7:0] nd[$];
    int         npq[$];
    a_iv = iv; a_id = id; a_or = ordy; a_flush = fl; rst = rs;
    #1;
    e_ir = (ordy || md.size() < N2) && !fl;
    e_ov = (md.size() > 0 && mp[0] == N2) && !fl;
    chk("n2_in_ready", 32'(a_ir), 32'(e_ir));
    chk("n2_out_valid", 32'(a_ov), 32'(e_ov));
    chk("n2_out_data", 32'(a_od), 32'(mlast));
`ifdef RISCV_V_HS_STAGE_OCC_EN
    chk("n2_occupancy", 32'(a_occ), 32'(md.size()));
`endif
    @(posedge clk);
    if (rs) begin
      md.delete(); mp.delete(); mlast = '0;
    end else if (fl) begin
      md.delete(); mp.delete();
    end else begin
      // Oldest word leaves only if the consumer takes it; each younger word
      // moves up one stage unless the word ahead of it is stuck right there.
      lim = ordy ? N2 + 1 : N2;
      for (int k = 0; k < md.size(); k++) begin
        np  = (mp[k] + 1 < lim) ? mp[k] + 1 : lim;
        lim = np - 1;
        if (np == N2) mlast = md[k];
        if (np <= N2) begin
          nd.push_back(md[k]);
          npq.push_back(np);
        end
      end
      if (iv && e_ir) begin
        nd.push_back(id);
        npq.push_back(1);
      end
      md = nd;
      mp = npq;
    end
    #1;
  endtask

  initial begin
    a_flush = 0; a_iv = 0; a_id = 0; a_or = 0;
    b_flush = 0; b_iv = 0; b_id = 0; b_or = 0;
    c_flush = 0; c_iv = 0; c_id = 0; c_or = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_n2_out_valid", 32'(a_ov), 32'd0);
    chk("rst_n2_out_data", 32'(a_od), 32'd0);
    chk("rst_n2_in_ready", 32'(a_ir), 32'd1);
    chk("rst_n3_out_valid", 32'(b_ov), 32'd0);
`ifdef RISCV_V_HS_STAGE_OCC_EN
    chk("rst_n2_occupancy", 32'(a_occ), 32'd0);
`endif
    mlast = '0;

    // Back-to-back with a free consumer.
    step2(1, 8'h11, 1, 0, 0);
    step2(1, 8'h22, 1, 0, 0);
    step2(1, 8'h33, 1, 0, 0);
    repeat (3) step2(0, 8'h00, 1, 0, 0);

    // Stalled consumer: fill, reject third, then drain in order.
    step2(1, 8'hA1, 0, 0, 0);
    step2(1, 8'hA2, 0, 0, 0);
    step2(1, 8'hA3, 0, 0, 0);
    step2(1, 8'hA3, 0, 0, 0);
    step2(1, 8'hA3, 1, 0, 0);
    repeat (3) step2(0, 8'h00, 1, 0, 0);

    // Full with simultaneous pop and push.
    step2(1, 8'h01, 0, 0, 0);
    step2(1, 8'h02, 0, 0, 0);
    step2(0, 8'h00, 0, 0, 0);
    step2(1, 8'h03, 1, 0, 0);
    step2(0, 8'h00, 0, 0, 0);
    repeat (3) step2(0, 8'h00, 1, 0, 0);

    // Flush with two words held and an offered word.
    step2(1, 8'h41, 0, 0, 0);
    step2(1, 8'h42, 0, 0, 0);
    step2(1, 8'h77, 0, 1, 0);
    repeat (3) step2(0, 8'h00, 1, 0, 0);

    // Reset mid-stream.
    step2(1, 8'h51, 0, 0, 0);
    step2(1, 8'h52, 0, 0, 0);
    step2(1, 8'h53, 1, 0, 1);
    step2(0, 8'h00, 1, 0, 0);
    chk("post_rst_out_data", 32'(a_od), 32'd0);

    // N=3 bubble collapse under a stalled consumer.
    b_or = 0; b_iv = 1; b_id = 8'h05;
    #1;
    chk("n3_in_ready_first", 32'(b_ir), 32'd1);
    @(posedge clk); #1;
    b_iv = 0;
    @(posedge clk); #1;
    chk("n3_out_valid_midway", 32'(b_ov), 32'd0);
    @(posedge clk); #1;
    chk("n3_out_valid_collapsed", 32'(b_ov), 32'd1);
    chk("n3_out_data_collapsed", 32'(b_od), 32'h05);
    b_iv = 1; b_id = 8'h06;
    #1;
    chk("n3_in_ready_second", 32'(b_ir), 32'd1);
    @(posedge clk); #1;
    b_iv = 0;
    chk("n3_out_data_held", 32'(b_od), 32'h05);
`ifdef RISCV_V_HS_STAGE_OCC_EN
    chk("n3_occupancy", 32'(b_occ), 32'd2);
`endif

    // N=0 combinational pass-through.
    for (int k = 0; k < 10; k++) begin
      c_iv    = 1'($urandom_range(0, 1));
      c_or    = 1'($urandom_range(0, 1));
      c_id    = 8'($urandom);
      c_flush = ($urandom_range(0, 3) == 0);
      #1;
      chk("n0_out_valid", 32'(c_ov), 32'(c_iv & ~c_flush));
      chk("n0_in_ready", 32'(c_ir), 32'(c_or & ~c_flush));
      chk("n0_out_data", 32'(c_od), 32'(c_id));
`ifdef RISCV_V_HS_STAGE_OCC_EN
      chk("n0_occupancy", 32'(c_occ), 32'd0);
`endif
      @(posedge clk); #1;
    end
    c_flush = 0;

    // Randomized traffic on N=2 against the model.
    for (int k = 0; k < 400; k++) begin
      step2(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
